// File: rtl/hls_deadlock_monitor_param.sv
// hls_deadlock_monitor_param
// Watches HLS dataflow processes and AXI-Stream ports. Declares a sticky
// deadlock once every process is stopped (idle, channel-blocked or
// AXIS-blocked), at least one AXIS port is blocked, and that condition has
// held for STOP_THRESH consecutive cycles. A snapshot of who was blocked is
// captured on entry and offered through a valid/ready report handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// MONITOR  | no stop condition seen, stop_cycles = 0
// PENDING  | stop condition held for fewer than STOP_THRESH cycles
// DEADLOCK | deadlock declared; block and snapshots held until clear/reset

module hls_deadlock_monitor_param #(
   parameter int                      NUM_PROC      = 9,
   parameter int                      NUM_AXIS      = 2,
   parameter logic [8*NUM_AXIS-1:0]   AXIS_PROC_MAP = {8'd8, 8'd0},
   parameter logic [NUM_AXIS-1:0]     AXIS_DIR      = 2'b10,
   parameter int                      STOP_THRESH   = 4,
   parameter int                      CNT_W         = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [NUM_AXIS-1:0]   axis_block_sigs,
   input  logic [NUM_PROC-1:0]   inst_idle_sigs,
   input  logic [NUM_PROC-1:0]   inst_block_sigs,
   output logic                  block,
   output logic                  block_pulse,
   output logic [2*NUM_AXIS-1:0] axis_block_info,
   output logic [NUM_PROC-1:0]   block_proc_vec,
   output logic [CNT_W-1:0]      stop_cycles,
   output logic                  report_valid,
   input  logic                  report_ready
);

   typedef enum logic [1:0] {
      MONITOR  = 2'd0,
      PENDING  = 2'd1,
      DEADLOCK = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [31:0]      THRESH_M1 = 32'(STOP_THRESH - 1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      stop_cycles_q, stop_cycles_d;
   logic                  block_pulse_q, block_pulse_d;
   logic                  report_valid_q, report_valid_d;
   logic [2*NUM_AXIS-1:0] axis_info_q, axis_info_d;
   logic [NUM_PROC-1:0]   proc_vec_q, proc_vec_d;

   logic [NUM_PROC-1:0]   axis_blk;
   logic [NUM_PROC-1:0]   stop;
   logic [2*NUM_AXIS-1:0] axis_code;
   logic                  cond;
   logic [CNT_W-1:0]      cnt_inc;

   // Fold AXIS port blocks onto their owning processes; build per-port codes.
   always_comb begin
      axis_blk  = '0;
      axis_code = '0;
      for (int p = 0; p < NUM_PROC; p++) begin
         for (int k = 0; k < NUM_AXIS; k++) begin
            if (AXIS_PROC_MAP[8*k +: 8] == 8'(p) && axis_block_sigs[k])
               axis_blk[p] = 1'b1;
         end
      end
      for (int k = 0; k < NUM_AXIS; k++) begin
         if (axis_block_sigs[k])
            axis_code[2*k +: 2] = AXIS_DIR[k] ? 2'b01 : 2'b10;
      end
      stop    = inst_idle_sigs | inst_block_sigs | axis_blk;
      cond    = enable & (&stop) & (|axis_blk);
      cnt_inc = (stop_cycles_q == CNT_MAX) ? stop_cycles_q : stop_cycles_q + 1'b1;
   end

   // Next-state, counter, report and snapshot logic.
   always_comb begin
      state_d        = state_q;
      stop_cycles_d  = stop_cycles_q;
      block_pulse_d  = 1'b0;
      report_valid_d = report_valid_q;
      axis_info_d    = axis_info_q;
      proc_vec_d     = proc_vec_q;
      case (state_q)
         MONITOR: begin
            stop_cycles_d = '0;
            if (!clear && cond) begin
               stop_cycles_d = cnt_inc;
               if (STOP_THRESH <= 1) begin
                  state_d        = DEADLOCK;
                  block_pulse_d  = 1'b1;
                  report_valid_d = 1'b1;
                  axis_info_d    = axis_code;
                  proc_vec_d     = inst_block_sigs | axis_blk;
               end else begin
                  state_d = PENDING;
               end
            end
         end
         PENDING: begin
            if (clear || !cond) begin
               state_d       = MONITOR;
               stop_cycles_d = '0;
            end else begin
               stop_cycles_d = cnt_inc;
               if (32'(stop_cycles_q) >= THRESH_M1) begin
                  state_d        = DEADLOCK;
                  block_pulse_d  = 1'b1;
                  report_valid_d = 1'b1;
                  axis_info_d    = axis_code;
                  proc_vec_d     = inst_block_sigs | axis_blk;
               end
            end
         end
         DEADLOCK: begin
            if (clear) begin
               state_d        = MONITOR;
               stop_cycles_d  = '0;
               report_valid_d = 1'b0;
               axis_info_d    = '0;
               proc_vec_d     = '0;
            end else begin
               if (cond)
                  stop_cycles_d = cnt_inc;
               if (report_valid_q && report_ready)
                  report_valid_d = 1'b0;
            end
         end
         default: begin
            state_d        = MONITOR;
            stop_cycles_d  = '0;
            report_valid_d = 1'b0;
            axis_info_d    = '0;
            proc_vec_d     = '0;
         end
      endcase
   end

   // State and output registers; reset discards everything with no report.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= MONITOR;
         stop_cycles_q  <= '0;
         block_pulse_q  <= 1'b0;
         report_valid_q <= 1'b0;
         axis_info_q    <= '0;
         proc_vec_q     <= '0;
      end else begin
         state_q        <= state_d;
         stop_cycles_q  <= stop_cycles_d;
         block_pulse_q  <= block_pulse_d;
         report_valid_q <= report_valid_d;
         axis_info_q    <= axis_info_d;
         proc_vec_q     <= proc_vec_d;
      end
   end

   assign block           = (state_q == DEADLOCK);
   assign block_pulse     = block_pulse_q;
   assign report_valid    = report_valid_q;
   assign axis_block_info = axis_info_q;
   assign block_proc_vec  = proc_vec_q;
   assign stop_cycles     = stop_cycles_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Directed bench for hls_deadlock_monitor_param with default parameters.
module tb_hls_deadlock_monitor_param;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic [1:0]  axis_block_sigs = '0;
   logic [8:0]  inst_idle_sigs = '0;
   logic [8:0]  inst_block_sigs = '0;
   logic        report_ready = 1'b0;
   logic        block, block_pulse, report_valid;
   logic [3:0]  axis_block_info;
   logic [8:0]  block_proc_vec;
   logic [15:0] stop_cycles;

   int errors = 0;
   int checks = 0;

   hls_deadlock_monitor_param dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .clear           (clear),
      .axis_block_sigs (axis_block_sigs),
      .inst_idle_sigs  (inst_idle_sigs),
      .inst_block_sigs (inst_block_sigs),
      .block           (block),
      .block_pulse     (block_pulse),
      .axis_block_info (axis_block_info),
      .block_proc_vec  (block_proc_vec),
      .stop_cycles     (stop_cycles),
      .report_valid    (report_valid),
      .report_ready    (report_ready)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // block, pulse, report_valid, info, vec, stop_cycles in one call
   task automatic chk_all(input string tag, input logic b, input logic p, input logic rv,
                          input logic [3:0] info, input logic [8:0] vec, input logic [15:0] sc);
      chk({tag, ".block"}, 32'(block), 32'(b));
      chk({tag, ".pulse"}, 32'(block_pulse), 32'(p));
      chk({tag, ".rvalid"}, 32'(report_valid), 32'(rv));
      chk({tag, ".info"}, 32'(axis_block_info), 32'(info));
      chk({tag, ".vec"}, 32'(block_proc_vec), 32'(vec));
      chk({tag, ".stop"}, 32'(stop_cycles), 32'(sc));
   endtask

   initial begin
      // reset
      tick(); tick();
      chk_all("reset", 0, 0, 0, 4'h0, 9'h000, 16'd0);
      reset = 1'b0;

      // case 1: deadlock on the 4th edge, port 0 (input) blocked
      enable = 1'b1; inst_idle_sigs = 9'h1FE; axis_block_sigs = 2'b01;
      tick(); chk_all("c1.e1", 0, 0, 0, 4'h0, 9'h000, 16'd1);
      tick(); chk_all("c1.e2", 0, 0, 0, 4'h0, 9'h000, 16'd2);
      tick(); chk_all("c1.e3", 0, 0, 0, 4'h0, 9'h000, 16'd3);
      tick(); chk_all("c1.e4", 1, 1, 1, 4'b0010, 9'h001, 16'd4);
      tick(); chk_all("c1.e5", 1, 0, 1, 4'b0010, 9'h001, 16'd5);

      // case 4: report held, stop_cycles freezes when cond drops, then handshake and clear
      axis_block_sigs = 2'b00;
      for (int i = 0; i < 4; i++) begin
         tick(); chk_all("c4.hold", 1, 0, 1, 4'b0010, 9'h001, 16'd5);
      end
      report_ready = 1'b1;
      tick(); chk_all("c4.hs", 1, 0, 0, 4'b0010, 9'h001, 16'd5);
      report_ready = 1'b0;
      tick(); chk_all("c4.norearm", 1, 0, 0, 4'b0010, 9'h001, 16'd5);
      clear = 1'b1;
      tick(); chk_all("c4.clear", 0, 0, 0, 4'h0, 9'h000, 16'd0);
      clear = 1'b0;

      // case 2: one-cycle break in the stop condition restarts the count
      inst_idle_sigs = 9'h1FE; axis_block_sigs = 2'b01;
      tick(); tick(); tick();
      chk_all("c2.pre", 0, 0, 0, 4'h0, 9'h000, 16'd3);
      inst_idle_sigs = 9'h1F6;
      tick(); chk_all("c2.break", 0, 0, 0, 4'h0, 9'h000, 16'd0);
      inst_idle_sigs = 9'h1FE;
      tick(); tick(); tick();
      chk_all("c2.r3", 0, 0, 0, 4'h0, 9'h000, 16'd3);
      tick(); chk_all("c2.r4", 1, 1, 1, 4'b0010, 9'h001, 16'd4);
      clear = 1'b1;
      tick(); chk_all("c2.clear", 0, 0, 0, 4'h0, 9'h000, 16'd0);
      clear = 1'b0;
      tick(); chk("c2.rearm.stop", 32'(stop_cycles), 32'd1);

      // case 3: all idle but no AXIS block never counts
      inst_idle_sigs = 9'h1FF; axis_block_sigs = 2'b00;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("c3.block", 32'(block), 32'd0);
         chk("c3.stop", 32'(stop_cycles), 32'd0);
      end

      // case 5: output port 1 blocked, owned by process 8
      inst_idle_sigs = 9'h0FF; axis_block_sigs = 2'b10;
      tick(); tick(); tick(); tick();
      chk_all("c5", 1, 1, 1, 4'b0100, 9'h100, 16'd4);
      // deadlock holds with enable low; count freezes because cond needs enable
      enable = 1'b0;
      tick(); chk_all("c5.en0", 1, 0, 1, 4'b0100, 9'h100, 16'd4);
      enable = 1'b1;
      tick(); chk_all("c5.en1", 1, 0, 1, 4'b0100, 9'h100, 16'd5);

      // case 6a: reset in DEADLOCK clears everything, overriding cond
      reset = 1'b1;
      tick(); chk_all("c6.reset", 0, 0, 0, 4'h0, 9'h000, 16'd0);
      reset = 1'b0;
      tick(); chk("c6.p1", 32'(stop_cycles), 32'd1);
      tick(); chk("c6.p2", 32'(stop_cycles), 32'd2);
      // case 6b: clear together with cond in PENDING wins
      clear = 1'b1;
      tick(); chk_all("c6.clr", 0, 0, 0, 4'h0, 9'h000, 16'd0);
      clear = 1'b0;
      tick(); chk("c6.restart", 32'(stop_cycles), 32'd1);
      // enable low in PENDING forces MONITOR
      enable = 1'b0;
      tick(); chk("c6.en0", 32'(stop_cycles), 32'd0);
      chk("c6.en0.block", 32'(block), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hls_deadlock_monitor_param.md
HLS_DEADLOCK_MONITOR_PARAM -- requirements
Module: hls_deadlock_monitor_param

Interface
REQ-001 Parameter NUM_PROC, default 9: number of dataflow processes monitored.
REQ-002 Parameter NUM_AXIS, default 2: number of AXI-Stream ports monitored.
REQ-003 Parameter AXIS_PROC_MAP, default {8'd8,8'd0}: 8-bit field k gives the process index owning axis port k.
REQ-004 Parameter AXIS_DIR, default 2'b10: bit k = 0 for an input (empty-blocked) port, 1 for an output (full-blocked) port.
REQ-005 Parameter STOP_THRESH, default 4, range 1..65535: consecutive stopped cycles required to declare deadlock.
REQ-006 Parameter CNT_W, default 16: width of the stall counter.
REQ-007 clock  in  1  clock; all logic on posedge.
REQ-008 reset  in  1  reset, synchronous, active-high.
REQ-009 enable  in  1  monitor enable.
REQ-010 clear  in  1  single-cycle request to drop a declared deadlock and rearm.
REQ-011 axis_block_sigs  in  NUM_AXIS  per-port AXIS block.
REQ-012 inst_idle_sigs  in  NUM_PROC  per-process idle.
REQ-013 inst_block_sigs  in  NUM_PROC  per-process channel block.
REQ-014 block  out  1  deadlock declared (sticky).
REQ-015 block_pulse  out  1  one-cycle strobe on deadlock entry.
REQ-016 axis_block_info  out  2*NUM_AXIS  per-port block code, captured at entry.
REQ-017 block_proc_vec  out  NUM_PROC  processes stopped by channel or AXIS block, captured at entry.
REQ-018 stop_cycles  out  CNT_W  current consecutive-stop count.
REQ-019 report_valid  out  1 / report_ready  in  1  report handshake.

Function
REQ-020 axis_blk[p] SHALL be the OR of axis_block_sigs[k] over every k with AXIS_PROC_MAP[k]==p. Processes with no mapped port get 0.
REQ-021 stop[p] SHALL be inst_idle_sigs[p] | inst_block_sigs[p] | axis_blk[p]. cond SHALL be enable & (AND of stop) & (OR of axis_blk).
REQ-022 The FSM SHALL have 3 states. MONITOR, PENDING, DEADLOCK.
REQ-023 MONITOR: on cond go to PENDING with stop_cycles=1. Otherwise stop_cycles=0.
REQ-024 PENDING: on !cond go to MONITOR with stop_cycles=0. On cond, stop_cycles increments, saturating at 2^CNT_W-1.
REQ-025 DEADLOCK SHALL be entered on the clock edge that samples the STOP_THRESH-th consecutive cond. With STOP_THRESH=1 this is MONITOR->DEADLOCK directly, one cycle after cond.
REQ-026 On entry, block=1, block_pulse=1 for exactly one cycle, and report_valid=1. Snapshots are taken from the inputs sampled on the entering edge.
REQ-027 axis_block_info[2k+1:2k] SHALL be 2'b10 if port k is blocked and AXIS_DIR[k]=0, 2'b01 if blocked and AXIS_DIR[k]=1, and 2'b00 if not blocked.
REQ-028 block_proc_vec[p] SHALL be inst_block_sigs[p] | axis_blk[p].
REQ-029 In DEADLOCK, block and the snapshots SHALL hold regardless of cond or enable. stop_cycles keeps counting while cond holds and holds its value otherwise.
REQ-030 report_valid SHALL drop on the cycle after report_valid & report_ready. It SHALL NOT re-assert until the next DEADLOCK entry.
REQ-031 clear in DEADLOCK SHALL return the FSM to MONITOR. On the next edge block, report_valid, snapshots and stop_cycles all go to 0. clear in MONITOR or PENDING SHALL force MONITOR with stop_cycles=0.
REQ-032 clear and cond in the same cycle: clear wins, and counting restarts from the next cycle.
REQ-033 enable=0 in MONITOR or PENDING SHALL force MONITOR with stop_cycles=0.
REQ-034 Outside DEADLOCK, axis_block_info and block_proc_vec SHALL read 0.

Reset
REQ-035 reset SHALL force MONITOR. All outputs go to 0 on the next edge, and reset overrides clear, enable and cond.
REQ-036 reset during PENDING or DEADLOCK SHALL discard the count and the snapshots with no report.

Verification (NUM_PROC=9, NUM_AXIS=2, STOP_THRESH=4, defaults)
REQ-037 Case 1. enable=1, idle=9'h1FE, axis=2'b01, held 4 cycles. Required: block=1 and block_pulse=1 after the 4th edge, axis_block_info=4'b0010, block_proc_vec=9'h001, stop_cycles=4.
REQ-038 Case 2. Same stimulus held 3 cycles, then idle[3]=0 for 1 cycle, then restored. Required: no block, stop_cycles returns to 0, and block appears only 4 cycles after restore.
REQ-039 Case 3. All processes idle, axis=2'b00, held 20 cycles. Required: block stays 0 and stop_cycles stays 0.
REQ-040 Case 4. Deadlock declared, report_ready held low 5 cycles, then pulsed. Required: report_valid high for those 5 cycles and low after the handshake, block still 1. Then clear pulsed: block=0 and axis_block_info=0 on the next edge.
REQ-041 Case 5. axis=2'b10 with idle=9'h0FF. Required: after 4 cycles, axis_block_info=4'b0100 and block_proc_vec=9'h100.
REQ-042 Case 6. reset asserted in DEADLOCK, or clear and cond asserted together in PENDING. Required: all outputs 0, or stop_cycles=0, on the next edge.
